hardwired_control_unit: RTL and testbench

- Moore-style control sequencer that produces every datapath enable, select, read and ALU-opcode signal, one T-step per clock.
- Per instruction: fetches into MAR/MDR/IR, decodes IR[31:27], then sequences the register-register ALU execute steps.
- Sits beside `datapath`. Its outputs drive the datapath's existing control ports directly.
- gra/grb/grc feed the select-and-encode block, which turns IR register fields into per-register enables and selects.

---
 rtl/hardwired_control_unit.sv | 197 +++++++++++++++++++
 tb/tb_hardwired_control_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hardwired_control_unit.sv
// rtl/hardwired_control_unit.sv - Moore control sequencer: fetch, decode and ALU execute T-steps
// Outputs are decoded from the state register and the opcode latched at the end of T2.
module hardwired_control_unit #(
  parameter int OPW = 5,
  parameter int IRW = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stop,
  input  logic [IRW-1:0] IR_Data,
  output logic           PC_select,
  output logic           Z_LO_select,
  output logic           Z_HI_select,
  output logic           MDR_select,
  output logic           MAR_enable,
  output logic           MDR_enable,
  output logic           read,
  output logic           IR_enable,
  output logic           PC_enable,
  output logic           PC_increment_enable,
  output logic           Y_enable,
  output logic           Z_enable,
  output logic           LO_enable,
  output logic           HI_enable,
  output logic           gra,
  output logic           grb,
  output logic           grc,
  output logic           r_in,
  output logic           r_out,
  output logic [OPW-1:0] alu_instruction,
  output logic           run,
  output logic [3:0]     state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd7,
    S_T1   = 4'd8,
    S_T2   = 4'd9,
    S_T3   = 4'd10,
    S_T4   = 4'd11,
    S_T5   = 4'd12,
    S_T6   = 4'd13,
    S_HALT = 4'd14
  } state_t;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  state_t         state_q;
  state_t         state_d;
  logic [OPW-1:0] op_q;
  logic           stop_req;

  logic is_binary;
  logic is_muldiv;
  logic is_unary;
  logic is_halt;

  // Only the opcode field of the instruction matters to the sequencer.
  logic unused_ir_bits;
  assign unused_ir_bits = ^IR_Data[IRW-OPW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      stop_req <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T2) begin
        op_q <= IR_Data[IRW-1 -: OPW];
      end
      if (stop && (state_q != S_IDLE)) begin
        stop_req <= 1'b1;
      end
    end
  end

  // add..rol are a contiguous opcode range; everything unrecognised falls through as nop.
  assign is_binary = (op_q >= OP_ADD) && (op_q <= OP_ROL);
  assign is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign is_unary  = (op_q == OP_NEG) || (op_q == OP_NOT);
  assign is_halt   = (op_q == OP_HALT);

  assign state = state_q;

  always_comb begin
    state_d             = S_IDLE;
    PC_select           = 1'b0;
    Z_LO_select         = 1'b0;
    Z_HI_select         = 1'b0;
    MDR_select          = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    read                = 1'b0;
    IR_enable           = 1'b0;
    PC_enable           = 1'b0;
    PC_increment_enable = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    LO_enable           = 1'b0;
    HI_enable           = 1'b0;
    gra                 = 1'b0;
    grb                 = 1'b0;
    grc                 = 1'b0;
    r_in                = 1'b0;
    r_out               = 1'b0;
    alu_instruction     = '0;
    run                 = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_T0;
      end
      S_T0: begin
        run                 = 1'b1;
        PC_select           = 1'b1;
        MAR_enable          = 1'b1;
        PC_increment_enable = 1'b1;
        Z_enable            = 1'b1;
        state_d             = S_T1;
      end
      S_T1: begin
        run         = 1'b1;
        Z_LO_select = 1'b1;
        PC_enable   = 1'b1;
        read        = 1'b1;
        MDR_enable  = 1'b1;
        state_d     = S_T2;
      end
      S_T2: begin
        run        = 1'b1;
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
        state_d    = S_T3;
      end
      S_T3: begin
        run = 1'b1;
        if (is_binary || is_muldiv) begin
          grb      = 1'b1;
          r_out    = 1'b1;
          Y_enable = 1'b1;
          state_d  = S_T4;
        end else if (is_unary) begin
          state_d = S_T4;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = stop_req ? S_HALT : S_T0;
        end
      end
      S_T4: begin
        run             = 1'b1;
        r_out           = 1'b1;
        Z_enable        = 1'b1;
        alu_instruction = op_q;
        if (is_unary) begin
          grb = 1'b1;
        end else begin
          grc = 1'b1;
        end
        state_d = S_T5;
      end
      S_T5: begin
        run         = 1'b1;
        Z_LO_select = 1'b1;
        if (is_muldiv) begin
          LO_enable = 1'b1;
          state_d   = S_T6;
        end else begin
          gra     = 1'b1;
          r_in    = 1'b1;
          state_d = stop_req ? S_HALT : S_T0;
        end
      end
      S_T6: begin
        run         = 1'b1;
        Z_HI_select = 1'b1;
        HI_enable   = 1'b1;
        state_d     = stop_req ? S_HALT : S_T0;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hardwired_control_unit.sv
// tb/tb_hardwired_control_unit.sv - directed self-checking bench for hardwired_control_unit
module tb_hardwired_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stop = 1'b0;
  logic [31:0] IR_Data = 32'h0;
  logic PC_select, Z_LO_select, Z_HI_select, MDR_select;
  logic MAR_enable, MDR_enable, read, IR_enable, PC_enable, PC_increment_enable;
  logic Y_enable, Z_enable, LO_enable, HI_enable;
  logic gra, grb, grc, r_in, r_out, run;
  logic [4:0] alu_instruction;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [3:0] IDLE = 4'd0, T0 = 4'd7, T1 = 4'd8, T2 = 4'd9, T3 = 4'd10;
  localparam logic [3:0] T4 = 4'd11, T5 = 4'd12, T6 = 4'd13, HALT = 4'd14;

  localparam logic [19:0] B_PCSEL = 20'h1 << 19, B_ZLO = 20'h1 << 18, B_ZHI = 20'h1 << 17;
  localparam logic [19:0] B_MDRSEL = 20'h1 << 16, B_MAR = 20'h1 << 15, B_MDREN = 20'h1 << 14;
  localparam logic [19:0] B_READ = 20'h1 << 13, B_IR = 20'h1 << 12, B_PC = 20'h1 << 11;
  localparam logic [19:0] B_PCINC = 20'h1 << 10, B_Y = 20'h1 << 9, B_Z = 20'h1 << 8;
  localparam logic [19:0] B_LO = 20'h1 << 7, B_HI = 20'h1 << 6, B_GRA = 20'h1 << 5;
  localparam logic [19:0] B_GRB = 20'h1 << 4, B_GRC = 20'h1 << 3, B_RIN = 20'h1 << 2;
  localparam logic [19:0] B_ROUT = 20'h1 << 1, B_RUN = 20'h1;

  localparam logic [19:0] C_T0 = B_PCSEL | B_MAR | B_PCINC | B_Z | B_RUN;
  localparam logic [19:0] C_T1 = B_ZLO | B_PC | B_READ | B_MDREN | B_RUN;
  localparam logic [19:0] C_T2 = B_MDRSEL | B_IR | B_RUN;
  localparam logic [19:0] C_B3 = B_GRB | B_ROUT | B_Y | B_RUN;
  localparam logic [19:0] C_B4 = B_GRC | B_ROUT | B_Z | B_RUN;
  localparam logic [19:0] C_B5 = B_ZLO | B_GRA | B_RIN | B_RUN;
  localparam logic [19:0] C_U4 = B_GRB | B_ROUT | B_Z | B_RUN;
  localparam logic [19:0] C_M5 = B_ZLO | B_LO | B_RUN;
  localparam logic [19:0] C_M6 = B_ZHI | B_HI | B_RUN;

  logic [19:0] ctrl;
  assign ctrl = {PC_select, Z_LO_select, Z_HI_select, MDR_select, MAR_enable, MDR_enable,
                 read, IR_enable, PC_enable, PC_increment_enable, Y_enable, Z_enable,
                 LO_enable, HI_enable, gra, grb, grc, r_in, r_out, run};

  hardwired_control_unit dut (
    .clk(clk), .reset(reset), .stop(stop), .IR_Data(IR_Data),
    .PC_select(PC_select), .Z_LO_select(Z_LO_select), .Z_HI_select(Z_HI_select),
    .MDR_select(MDR_select), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .read(read), .IR_enable(IR_enable), .PC_enable(PC_enable),
    .PC_increment_enable(PC_increment_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .LO_enable(LO_enable), .HI_enable(HI_enable), .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .alu_instruction(alu_instruction), .run(run), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    stop  = 1'b1;
    tick();
    tick();
    stop = 1'b0;
    n_cmp++;
    if (state !== IDLE) begin
      n_bad++;
      $display("FAIL reset_state: got %0d want %0d", state, IDLE);
    end
    n_cmp++;
    if (ctrl !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %05h want 00000", ctrl);
    end
    n_cmp++;
    if (alu_instruction !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_alu: got %02h want 00", alu_instruction);
    end
  endtask

  // Starts from IDLE: fetch + shr, opcode latch checked by changing IR_Data after T3.
  task automatic test_fetch_shr;
    logic [3:0]  es [7] = '{T0, T1, T2, T3, T4, T5, T0};
    logic [19:0] ec [7] = '{C_T0, C_T1, C_T2, C_B3, C_B4, C_B5, C_T0};
    logic [4:0]  ea [7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00111, 5'd0, 5'd0};
    IR_Data = 32'h389A8000;
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 3) IR_Data = 32'h78000000;
      n_cmp++;
      if ({state, ctrl, alu_instruction} !== {es[i], ec[i], ea[i]}) begin
        n_bad++;
        $display("FAIL shr[%0d]: got state=%0d ctrl=%05h alu=%02h want state=%0d ctrl=%05h alu=%02h",
                 i, state, ctrl, alu_instruction, es[i], ec[i], ea[i]);
      end
    end
  endtask

  task automatic test_mul;
    logic [3:0]  es [7] = '{T1, T2, T3, T4, T5, T6, T0};
    logic [19:0] ec [7] = '{C_T1, C_T2, C_B3, C_B4, C_M5, C_M6, C_T0};
    logic [4:0]  ea [7] = '{5'd0, 5'd0, 5'd0, 5'b01111, 5'd0, 5'd0, 5'd0};
    IR_Data = 32'h78000000;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if ({state, ctrl, alu_instruction} !== {es[i], ec[i], ea[i]}) begin
        n_bad++;
        $display("FAIL mul[%0d]: got state=%0d ctrl=%05h alu=%02h want state=%0d ctrl=%05h alu=%02h",
                 i, state, ctrl, alu_instruction, es[i], ec[i], ea[i]);
      end
    end
  endtask

  task automatic test_nop;
    logic [31:0] irs [2] = '{32'hD0000000, 32'hF8000000};
    logic [3:0]  es [4] = '{T1, T2, T3, T0};
    logic [19:0] ec [4] = '{C_T1, C_T2, B_RUN, C_T0};
    for (int k = 0; k < 2; k++) begin
      IR_Data = irs[k];
      for (int i = 0; i < 4; i++) begin
        tick();
        n_cmp++;
        if ({state, ctrl, alu_instruction} !== {es[i], ec[i], 5'd0}) begin
          n_bad++;
          $display("FAIL nop%0d[%0d]: got state=%0d ctrl=%05h alu=%02h want state=%0d ctrl=%05h alu=00",
                   k, i, state, ctrl, alu_instruction, es[i], ec[i]);
        end
      end
    end
  endtask

  // neg immediately followed by sub, no idle cycles between instructions.
  task automatic test_back_to_back;
    logic [31:0] irs [2] = '{32'h88000000, 32'h20000000};
    logic [4:0]  ops [2] = '{5'b10001, 5'b00100};
    logic [3:0]  es [6] = '{T1, T2, T3, T4, T5, T0};
    logic [19:0] ec [6];
    logic [4:0]  ea;
    for (int k = 0; k < 2; k++) begin
      IR_Data = irs[k];
      ec = '{C_T1, C_T2, (k == 0) ? B_RUN : C_B3, (k == 0) ? C_U4 : C_B4, C_B5, C_T0};
      for (int i = 0; i < 6; i++) begin
        tick();
        ea = (i == 3) ? ops[k] : 5'd0;
        n_cmp++;
        if ({state, ctrl, alu_instruction} !== {es[i], ec[i], ea}) begin
          n_bad++;
          $display("FAIL b2b%0d[%0d]: got state=%0d ctrl=%05h alu=%02h want state=%0d ctrl=%05h alu=%02h",
                   k, i, state, ctrl, alu_instruction, es[i], ec[i], ea);
        end
      end
    end
  endtask

  task automatic test_stop;
    logic [3:0]  es [9] = '{T1, T2, T3, T4, T5, HALT, HALT, HALT, HALT};
    logic [19:0] ec [9] = '{C_T1, C_T2, C_B3, C_B4, C_B5, 20'h0, 20'h0, 20'h0, 20'h0};
    logic [4:0]  ea [9] = '{5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    IR_Data = 32'h18000000;
    for (int i = 0; i < 9; i++) begin
      tick();
      stop = (i == 0);
      n_cmp++;
      if ({state, ctrl, alu_instruction} !== {es[i], ec[i], ea[i]}) begin
        n_bad++;
        $display("FAIL stop[%0d]: got state=%0d ctrl=%05h alu=%02h want state=%0d ctrl=%05h alu=%02h",
                 i, state, ctrl, alu_instruction, es[i], ec[i], ea[i]);
      end
    end
  endtask

  // Arms stop_req, resets during T4, then checks stop_req was cleared and IDLE ignores stop.
  task automatic test_reset_mid;
    logic [3:0]  es [6] = '{T1, T2, T3, T4, T5, T0};
    logic [19:0] ec [6] = '{C_T1, C_T2, C_B3, C_B4, C_B5, C_T0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (state !== T0) begin
      n_bad++;
      $display("FAIL rmid_restart: got state=%0d want %0d", state, T0);
    end
    IR_Data = 32'h18000000;
    for (int i = 0; i < 4; i++) begin
      tick();
      stop = (i == 0);
    end
    n_cmp++;
    if (state !== T4) begin
      n_bad++;
      $display("FAIL rmid_at_t4: got state=%0d want %0d", state, T4);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({state, ctrl, alu_instruction} !== {IDLE, 20'h0, 5'd0}) begin
      n_bad++;
      $display("FAIL rmid_idle: got state=%0d ctrl=%05h alu=%02h want state=0 ctrl=00000 alu=00",
               state, ctrl, alu_instruction);
    end
    reset = 1'b0;
    stop  = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if ({state, ctrl} !== {T0, C_T0}) begin
      n_bad++;
      $display("FAIL rmid_release: got state=%0d ctrl=%05h want state=%0d ctrl=%05h",
               state, ctrl, T0, C_T0);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({state, ctrl} !== {es[i], ec[i]}) begin
        n_bad++;
        $display("FAIL rmid_add[%0d]: got state=%0d ctrl=%05h want state=%0d ctrl=%05h",
                 i, state, ctrl, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_halt;
    logic [3:0]  es [4] = '{T1, T2, T3, HALT};
    logic [19:0] ec [4] = '{C_T1, C_T2, B_RUN, 20'h0};
    IR_Data = 32'hD8000000;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({state, ctrl} !== {es[i], ec[i]}) begin
        n_bad++;
        $display("FAIL halt[%0d]: got state=%0d ctrl=%05h want state=%0d ctrl=%05h",
                 i, state, ctrl, es[i], ec[i]);
      end
    end
    IR_Data = 32'h18000000;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({state, ctrl, alu_instruction} !== {HALT, 20'h0, 5'd0}) begin
        n_bad++;
        $display("FAIL halt_hold[%0d]: got state=%0d ctrl=%05h alu=%02h want state=14 ctrl=00000 alu=00",
                 i, state, ctrl, alu_instruction);
      end
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (state !== IDLE) begin
      n_bad++;
      $display("FAIL halt_exit: got state=%0d want %0d", state, IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_shr();
    test_mul();
    test_nop();
    test_back_to_back();
    test_stop();
    test_reset_mid();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
